// File: rtl/alu_pipe_pkg.sv
// alu_pipe_pkg: shared types and constants for the alu_pipe block.
//   alu_op_e     - 4-bit opcode encoding seen on the op port
//   FLAG_*       - bit positions of N, Z, C, V inside the {N,Z,C,V} flag vector
//   mul_state_e  - control states (only IDLE is reachable without ALU_PIPE_MUL_EN)
//   shift_kind_e - selector for the shared barrel shifter
package alu_pipe_pkg;

   typedef enum logic [3:0] {
      OP_PASSB = 4'd0,
      OP_ADD   = 4'd1,
      OP_SUB   = 4'd2,
      OP_ADC   = 4'd3,
      OP_SBC   = 4'd4,
      OP_AND   = 4'd5,
      OP_OR    = 4'd6,
      OP_XOR   = 4'd7,
      OP_LSL   = 4'd8,
      OP_LSR   = 4'd9,
      OP_ASR   = 4'd10,
      OP_MUL   = 4'd11,
      OP_RSV12 = 4'd12,
      OP_RSV13 = 4'd13,
      OP_RSV14 = 4'd14,
      OP_RSV15 = 4'd15
   } alu_op_e;

   localparam int FLAG_N = 3;
   localparam int FLAG_Z = 2;
   localparam int FLAG_C = 1;
   localparam int FLAG_V = 0;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_MUL_RUN  = 2'd1,
      ST_MUL_DONE = 2'd2
   } mul_state_e;

   typedef enum logic [1:0] {
      SH_LSL = 2'd0,
      SH_LSR = 2'd1,
      SH_ASR = 2'd2
   } shift_kind_e;

endpackage

// File: rtl/alu_pipe_shift.sv
// alu_pipe_shift: combinational barrel shifter shared by LSL/LSR/ASR.
//   val_i  [WIDTH] value to shift
//   amt_i  [AW]    shift amount
//   kind_i         LSL, LSR or ASR
//   res_o  [WIDTH] shifted value
//   cout_o         last bit shifted out (meaningless when amt_i == 0)
module alu_pipe_shift
   import alu_pipe_pkg::*;
#(
   parameter int WIDTH = 16,
   parameter int AW    = 4
) (
   input  logic [WIDTH-1:0] val_i,
   input  logic [AW-1:0]    amt_i,
   input  shift_kind_e      kind_i,
   output logic [WIDTH-1:0] res_o,
   output logic             cout_o
);

   // One extra bit on the side bits leave from catches the last bit shifted out.
   logic [WIDTH:0]        lsl_w;
   logic [WIDTH:0]        lsr_w;
   logic signed [WIDTH:0] asr_in_w;
   logic signed [WIDTH:0] asr_w;

   always_comb begin
      lsl_w    = {1'b0, val_i} << amt_i;
      lsr_w    = {val_i, 1'b0} >> amt_i;
      asr_in_w = {val_i, 1'b0};
      asr_w    = asr_in_w >>> amt_i;
      case (kind_i)
         SH_LSR: begin
            res_o  = lsr_w[WIDTH:1];
            cout_o = lsr_w[0];
         end
         SH_ASR: begin
            res_o  = asr_w[WIDTH:1];
            cout_o = asr_w[0];
         end
         default: begin
            res_o  = lsl_w[WIDTH-1:0];
            cout_o = lsl_w[WIDTH];
         end
      endcase
   end

endmodule

// File: rtl/alu_pipe.sv
// alu_pipe: handshaked WIDTH-bit ALU with registered result and NZCV flags.
//   clk, rst_n           clock, asynchronous active-low reset
//   in_valid/in_ready    operation handshake (a, b, op, set_flags)
//   out_valid/out_ready  result handshake (result plus current flags)
//   negative..overflow   architectural flag register N, Z, C, V
//   busy                 high while the multiplier iterates
//   dbg_state_o          control state (mul_state_e encoding)
// Optional feature: define ALU_PIPE_MUL_EN to build the iterative multiplier
// (opcode 11). Without it opcode 11 behaves like the reserved opcodes.
// Handshake: a transfer happens on a rising edge where valid && ready; the
// producer holds its payload stable while valid is high and not yet accepted.
module alu_pipe
   import alu_pipe_pkg::*;
#(
   parameter int         WIDTH    = 16,
   parameter logic [3:0] FLAG_RST = 4'b0000
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [3:0]       op,
   input  logic             set_flags,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic             negative,
   output logic             zero,
   output logic             carry_out,
   output logic             overflow,
   output logic             busy,
   output logic [1:0]       dbg_state_o
);

   localparam int AW = $clog2(WIDTH);

   alu_op_e          op_e;
   logic             can_load, accept, is_mul;
   logic [WIDTH-1:0] result_q, result_d;
   logic [3:0]       flags_q, flags_d;
   logic             out_valid_q, out_valid_d;
   mul_state_e       state_q;
   logic             busy_q;

   logic             is_sub, carry_in, add_c, add_v;
   logic [WIDTH-1:0] b_eff;
   logic [WIDTH:0]   sum;
   shift_kind_e      sh_kind;
   logic [WIDTH-1:0] sh_res;
   logic             sh_cout;
   logic [WIDTH-1:0] sc_res;
   logic [3:0]       sc_flags;

   assign op_e     = alu_op_e'(op);
   assign can_load = !out_valid_q || out_ready;
   assign in_ready = (state_q == ST_IDLE) && can_load;
   assign accept   = in_valid && in_ready;

   // Single adder: subtraction is a + ~b + carry_in, so its carry out is NOT borrow.
   always_comb begin
      is_sub = (op_e == OP_SUB) || (op_e == OP_SBC);
      b_eff  = is_sub ? ~b : b;
      case (op_e)
         OP_SUB:         carry_in = 1'b1;
         OP_ADC, OP_SBC: carry_in = flags_q[FLAG_C];
         default:        carry_in = 1'b0;
      endcase
      sum   = {1'b0, a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, carry_in};
      add_c = sum[WIDTH];
      // carry into MSB is recovered from the MSB sum bit and its two inputs
      add_v = (a[WIDTH-1] ^ b_eff[WIDTH-1] ^ sum[WIDTH-1]) ^ sum[WIDTH];
   end

   always_comb begin
      case (op_e)
         OP_LSR:  sh_kind = SH_LSR;
         OP_ASR:  sh_kind = SH_ASR;
         default: sh_kind = SH_LSL;
      endcase
   end

   alu_pipe_shift #(.WIDTH(WIDTH), .AW(AW)) u_shift (
      .val_i  (a),
      .amt_i  (b[AW-1:0]),
      .kind_i (sh_kind),
      .res_o  (sh_res),
      .cout_o (sh_cout)
   );

   // Result and would-be flags of the single-cycle opcodes.
   always_comb begin
      sc_res   = '0;
      sc_flags = flags_q;
      case (op_e)
         OP_PASSB: sc_res = b;
         OP_ADD, OP_SUB, OP_ADC, OP_SBC: begin
            sc_res           = sum[WIDTH-1:0];
            sc_flags[FLAG_C] = add_c;
            sc_flags[FLAG_V] = add_v;
         end
         OP_AND: sc_res = a & b;
         OP_OR:  sc_res = a | b;
         OP_XOR: sc_res = a ^ b;
         OP_LSL, OP_LSR, OP_ASR: begin
            sc_res = sh_res;
            if (b[AW-1:0] != '0) sc_flags[FLAG_C] = sh_cout;
         end
         default: sc_res = '0;
      endcase
      // reserved opcodes (and MUL, which never uses this path) leave flags alone
      if (op < 4'd11) begin
         sc_flags[FLAG_N] = sc_res[WIDTH-1];
         sc_flags[FLAG_Z] = (sc_res == '0);
      end
   end

`ifdef ALU_PIPE_MUL_EN
   localparam int CW = $clog2(WIDTH + 1);

   logic [CW-1:0]    cnt_q;
   logic [WIDTH-1:0] acc_q, mcand_q, mplier_q;
   logic             mul_sf_q;

   assign is_mul = (op_e == OP_MUL);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= ST_IDLE;
         cnt_q    <= '0;
         acc_q    <= '0;
         mcand_q  <= '0;
         mplier_q <= '0;
         mul_sf_q <= 1'b0;
         busy_q   <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (accept && is_mul) begin
                  state_q  <= ST_MUL_RUN;
                  cnt_q    <= CW'(WIDTH);
                  acc_q    <= '0;
                  mcand_q  <= a;
                  mplier_q <= b;
                  mul_sf_q <= set_flags;
                  busy_q   <= 1'b1;
               end
            end
            ST_MUL_RUN: begin
               // only the low WIDTH product bits are kept, so mcand may drop its MSBs
               if (mplier_q[0]) acc_q <= acc_q + mcand_q;
               mcand_q  <= mcand_q << 1;
               mplier_q <= mplier_q >> 1;
               cnt_q    <= cnt_q - CW'(1);
               if (cnt_q == CW'(1)) begin
                  state_q <= ST_MUL_DONE;
                  busy_q  <= 1'b0;
               end
            end
            ST_MUL_DONE: begin
               if (can_load) state_q <= ST_IDLE;
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end
`else
   assign is_mul  = 1'b0;
   assign state_q = ST_IDLE;
   assign busy_q  = 1'b0;
`endif

   always_comb begin
      result_d    = result_q;
      flags_d     = flags_q;
      out_valid_d = out_valid_q && !out_ready;
      if (accept && !is_mul) begin
         result_d    = sc_res;
         out_valid_d = 1'b1;
         if (set_flags) flags_d = sc_flags;
      end
`ifdef ALU_PIPE_MUL_EN
      if ((state_q == ST_MUL_DONE) && can_load) begin
         result_d    = acc_q;
         out_valid_d = 1'b1;
         if (mul_sf_q) begin
            flags_d[FLAG_N] = acc_q[WIDTH-1];
            flags_d[FLAG_Z] = (acc_q == '0);
         end
      end
`endif
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         result_q    <= '0;
         flags_q     <= FLAG_RST;
         out_valid_q <= 1'b0;
      end else begin
         result_q    <= result_d;
         flags_q     <= flags_d;
         out_valid_q <= out_valid_d;
      end
   end

   assign result      = result_q;
   assign out_valid   = out_valid_q;
   assign negative    = flags_q[FLAG_N];
   assign zero        = flags_q[FLAG_Z];
   assign carry_out   = flags_q[FLAG_C];
   assign overflow    = flags_q[FLAG_V];
   assign busy        = busy_q;
   assign dbg_state_o = state_q;

endmodule

// File: tb/tb_alu_pipe.sv
// tb_alu_pipe: randomized and directed stimulus for alu_pipe (WIDTH=16,
// FLAG_RST=4'b0010) with a queue-based scoreboard and an arithmetic model.
module tb_alu_pipe;

   localparam int         W        = 16;
   localparam logic [3:0] FLAG_RST = 4'b0010;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          in_valid;
   logic          in_ready;
   logic [W-1:0]  a, b;
   logic [3:0]    op;
   logic          set_flags;
   logic          out_valid;
   logic          out_ready;
   logic [W-1:0]  result;
   logic          negative, zero, carry_out, overflow, busy;
   logic [1:0]    dbg_state;

   int            checks = 0;
   int            errors = 0;
   int            rdy_mode = 0;   // 0: hold low, 1: hold high, 2: random
   logic [3:0]    mflags;
   logic [W+3:0]  exp_q[$];       // {N,Z,C,V, result}

   alu_pipe #(.WIDTH(W), .FLAG_RST(FLAG_RST)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .a           (a),
      .b           (b),
      .op          (op),
      .set_flags   (set_flags),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .result      (result),
      .negative    (negative),
      .zero        (zero),
      .carry_out   (carry_out),
      .overflow    (overflow),
      .busy        (busy),
      .dbg_state_o (dbg_state)
   );

   // ---------------- clock / reset ----------------
   always #5 clk = ~clk;

   task automatic apply_reset();
      rst_n    = 1'b0;
      in_valid = 1'b0;
      exp_q.delete();
      mflags   = FLAG_RST;
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endfunction

   // ---------------- reference model ----------------
   task automatic predict(input logic [3:0] o, input logic [W-1:0] pa, input logic [W-1:0] pb,
                          input logic sf);
      longint ua, ub, sa, sb, full, sfull, cin;
      int n;
      logic [W-1:0] r;
      logic c_new, v_new, nz;
      ua = pa; ub = pb; sa = $signed(pa); sb = $signed(pb);
      n = pb[3:0];
      cin = mflags[1];
      c_new = mflags[1]; v_new = mflags[0]; nz = 1'b1; r = '0;
      case (o)
         4'd0: r = pb;
         4'd1: begin full = ua + ub; sfull = sa + sb; r = full[W-1:0];
                  c_new = (full > 65535); v_new = (sfull > 32767) || (sfull < -32768); end
         4'd2: begin full = ua - ub; sfull = sa - sb; r = full[W-1:0];
                  c_new = (ua >= ub); v_new = (sfull > 32767) || (sfull < -32768); end
         4'd3: begin full = ua + ub + cin; sfull = sa + sb + cin; r = full[W-1:0];
                  c_new = (full > 65535); v_new = (sfull > 32767) || (sfull < -32768); end
         4'd4: begin full = ua - ub - (1 - cin); sfull = sa - sb - (1 - cin); r = full[W-1:0];
                  c_new = (full >= 0); v_new = (sfull > 32767) || (sfull < -32768); end
         4'd5: r = pa & pb;
         4'd6: r = pa | pb;
         4'd7: r = pa ^ pb;
         4'd8: begin full = ua << n; r = full[W-1:0]; if (n != 0) c_new = full[W]; end
         4'd9: begin r = pa >> n; if (n != 0) c_new = pa[n-1]; end
         4'd10: begin sfull = sa >>> n; r = sfull[W-1:0];
                   if (n != 0) begin sfull = sa >>> (n - 1); c_new = sfull[0]; end end
`ifdef ALU_PIPE_MUL_EN
         4'd11: begin full = ua * ub; r = full[W-1:0]; end
`endif
         default: begin r = '0; nz = 1'b0; end
      endcase
      if (sf && nz) mflags = {r[W-1], (r == '0), c_new, v_new};
      exp_q.push_back({mflags, r});
   endtask

   // ---------------- driver ----------------
   task automatic issue(input logic [3:0] o, input logic [W-1:0] pa, input logic [W-1:0] pb,
                        input logic sf);
      int n = 0;
      @(negedge clk);
      op = o; a = pa; b = pb; set_flags = sf; in_valid = 1'b1;
      #1;
      while (!in_ready && n < 200) begin
         @(negedge clk); #1; n++;
      end
      if (!in_ready) begin
         checks++; errors++;
         $display("FAIL issue_timeout: in_ready got 0 expected 1 after %0d cycles", n);
         in_valid = 1'b0;
      end else begin
         predict(o, pa, pb, sf);
         @(posedge clk); #1;
         in_valid = 1'b0;
      end
   endtask

   task automatic drain();
      int n = 0;
      rdy_mode = 1;
      while ((exp_q.size() != 0 || out_valid) && n < 200) begin
         @(posedge clk); #1; n++;
      end
      check("drain_queue_empty", exp_q.size(), 0);
   endtask

   // out_ready policy, updated on each falling edge
   initial begin
      out_ready = 1'b0;
      forever begin
         @(negedge clk);
         case (rdy_mode)
            0:       out_ready = 1'b0;
            1:       out_ready = 1'b1;
            default: out_ready = 1'($urandom_range(0, 1));
         endcase
      end
   end

   // ---------------- scoreboard monitor ----------------
   initial begin
      logic [W+3:0] e;
      forever begin
         @(negedge clk); #2;
         if (rst_n && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
               checks++; errors++;
               $display("FAIL unexpected_output: got result %0h with empty queue", result);
            end else begin
               e = exp_q.pop_front();
               check("sb_result", result, e[W-1:0]);
               check("sb_flags", {negative, zero, carry_out, overflow}, e[W+3:W]);
            end
         end
      end
   end

   // ---------------- watchdog ----------------
   initial begin
      #2000000;
      errors++;
      $display("FAIL watchdog: simulation time limit reached");
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   // ---------------- main sequence ----------------
   initial begin
      in_valid = 1'b0; a = '0; b = '0; op = '0; set_flags = 1'b0;
      apply_reset();
      #1;
      check("rst_result", result, 0);
      check("rst_out_valid", out_valid, 0);
      check("rst_flags", {negative, zero, carry_out, overflow}, 4'b0010);
      check("rst_in_ready", in_ready, 1);
      check("rst_busy", busy, 0);

      rdy_mode = 1;
      issue(4'd1, 16'h7FFF, 16'h0001, 1'b1);
      check("add_ovf_res", result, 16'h8000);
      check("add_ovf_flags", {negative, zero, carry_out, overflow}, 4'b1001);
      issue(4'd2, 16'h0003, 16'h0005, 1'b1);
      check("sub_res", result, 16'hFFFE);
      check("sub_c", carry_out, 0);
      issue(4'd2, 16'h0005, 16'h0003, 1'b1);
      check("sub_c_set", carry_out, 1);
      issue(4'd1, 16'hFFFF, 16'h0001, 1'b1);
      check("add_wrap_flags", {negative, zero, carry_out, overflow}, 4'b0110);
      issue(4'd3, 16'h0000, 16'h0000, 1'b1);
      check("adc_chain_res", result, 16'h0001);
      issue(4'd9, 16'h0003, 16'h0001, 1'b1);
      check("lsr_res", result, 16'h0001);
      check("lsr_c", carry_out, 1);
      issue(4'd8, 16'h0005, 16'h0000, 1'b1);
      check("lsl0_c_kept", carry_out, 1);
      issue(4'd13, 16'h1234, 16'h5678, 1'b1);
      check("rsv_res", result, 0);

      // backpressure: pending result blocks new input and stays stable
      drain();
      rdy_mode = 0;
      issue(4'd7, 16'hF0F0, 16'h0FF0, 1'b0);
      for (int i = 0; i < 4; i++) begin
         @(posedge clk); #1;
         check("bp_in_ready", in_ready, 0);
         check("bp_result", result, 16'hFF00);
      end
      drain();

`ifdef ALU_PIPE_MUL_EN
      begin
         int busy_cnt = 0;
         int lat = 0;
         int rdy_seen = 0;
         rdy_mode = 0;
         issue(4'd11, 16'd300, 16'd300, 1'b1);
         for (int i = 0; i < 40 && !out_valid; i++) begin
            if (busy) busy_cnt++;
            if (in_ready) rdy_seen++;
            @(posedge clk); #1;
            lat++;
         end
         check("mul_busy_cycles", busy_cnt, 16);
         check("mul_latency", lat, 17);
         check("mul_in_ready_low", rdy_seen, 0);
         repeat (3) @(posedge clk);
         #1;
         check("mul_res_held", result, 16'h5F90);
         check("mul_valid_held", out_valid, 1);
         drain();
      end
      rdy_mode = 0;
      issue(4'd11, 16'h1234, 16'h0055, 1'b1);
      repeat (5) @(posedge clk);
      #1;
      check("mid_mul_busy", busy, 1);
`else
      rdy_mode = 0;
      issue(4'd11, 16'h1234, 16'h0055, 1'b1);
      check("op11_rsv_res", result, 0);
      check("op11_valid", out_valid, 1);
`endif
      #2;
      rst_n = 1'b0;
      #1;
      check("async_rst_valid", out_valid, 0);
      check("async_rst_busy", busy, 0);
      check("async_rst_flags", {negative, zero, carry_out, overflow}, 4'b0010);
      apply_reset();

      // randomized traffic with random backpressure
      rdy_mode = 2;
      for (int i = 0; i < 300; i++) begin
         logic [3:0] ro;
         logic [W-1:0] ra, rb;
         ro = 4'($urandom_range(0, 15));
         ra = ($urandom_range(0, 3) == 0) ? W'($urandom_range(0, 3)) : W'($urandom);
         rb = ($urandom_range(0, 3) == 0) ? W'($urandom_range(0, 3)) : W'($urandom);
         if ($urandom_range(0, 7) == 0) ra = 16'h7FFF;
         issue(ro, ra, rb, 1'($urandom_range(0, 1)));
         repeat ($urandom_range(0, 1)) @(negedge clk);
      end
      drain();
      @(posedge clk); #1;
      check("final_out_valid", out_valid, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
